// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with a multi-cycle shift-add multiplier.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  request handshake carrying op, a, b
//   op                 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                      101 SHL, 110 SHR, 111 MUL
//   a, b               unsigned operands (b is the shift amount for SHL/SHR)
//   out_valid/out_ready response handshake
//   result, carry,     registered result, carry/borrow/overflow flag,
//   zero, led_n        result-is-zero flag and active-low LED copy of result
//
// Non-MUL ops complete on the accepting edge. MUL runs WIDTH shift-add
// cycles over b's bits (LSB first) into a 2*WIDTH accumulator. The result
// is held in RESP until the consumer takes it.
module alu_seq #(
   parameter int WIDTH = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic [WIDTH-1:0] led_n
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   // Shift amounts at or above WIDTH clear the result.
   localparam logic [WIDTH:0]   SHIFT_LIM = (WIDTH + 1)'(WIDTH);

   state_e                 state_q, state_d;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;
   logic [WIDTH-1:0]       result_q, result_d;
   logic                   carry_q, carry_d;
   logic                   zero_q, zero_d;
   logic [WIDTH-1:0]       led_n_q, led_n_d;
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   logic [2*WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]       mplier_q, mplier_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [WIDTH-1:0]       alu_res;
   logic                   alu_cy;
   logic [WIDTH:0]         sum_w;
   logic [2*WIDTH-1:0]     acc_step;

   // Single-cycle ALU for every op except MUL.
   always_comb begin
      alu_res = '0;
      alu_cy  = 1'b0;
      sum_w   = '0;
      case (op)
         OP_ADD: begin
            sum_w   = {1'b0, a} + {1'b0, b};
            alu_res = sum_w[WIDTH-1:0];
            alu_cy  = sum_w[WIDTH];
         end
         OP_SUB: begin
            alu_res = a - b;
            alu_cy  = (a < b);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_SHL: begin
            if ({1'b0, b} >= SHIFT_LIM) begin
               alu_res = '0;
            end else begin
               alu_res = a << b;
            end
         end
         OP_SHR: begin
            if ({1'b0, b} >= SHIFT_LIM) begin
               alu_res = '0;
            end else begin
               alu_res = a >> b;
            end
         end
         default: alu_res = '0;
      endcase
   end

   // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set.
   always_comb begin
      if (mplier_q[0]) begin
         acc_step = acc_q + mcand_q;
      end else begin
         acc_step = acc_q;
      end
   end

   // Next-state and next-output logic for the IDLE / MUL / RESP sequencer.
   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      led_n_d     = led_n_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               in_ready_d = 1'b0;
               if (op == OP_MUL) begin
                  acc_d    = '0;
                  cnt_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, a};
                  mplier_d = b;
                  state_d  = ST_MUL;
               end else begin
                  result_d    = alu_res;
                  carry_d     = alu_cy;
                  zero_d      = (alu_res == '0);
                  led_n_d     = ~alu_res;
                  out_valid_d = 1'b1;
                  state_d     = ST_RESP;
               end
            end else begin
               // Also lifts in_ready on the first cycle out of reset.
               in_ready_d = 1'b1;
            end
         end
         ST_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1'b1;
            mplier_d = mplier_q >> 1'b1;
            cnt_d    = cnt_q + CNT_ONE;
            if (cnt_q == LAST_CNT) begin
               result_d    = acc_step[WIDTH-1:0];
               carry_d     = |acc_step[2*WIDTH-1:WIDTH];
               zero_d      = (acc_step[WIDTH-1:0] == '0);
               led_n_d     = ~acc_step[WIDTH-1:0];
               out_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_RESP: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset wins over every handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         led_n_q     <= '1;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         led_n_q     <= led_n_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign led_n     = led_n_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq (WIDTH=3 main
// instance plus a WIDTH=8 instance for wide-operand cases).
module tb_alu_seq;

   localparam int W = 3;

   logic         clk;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [2:0]   op;
   logic [W-1:0] a, b, result, led_n;
   logic         carry, zero;

   logic         in_valid8, in_ready8, out_valid8, out_ready8;
   logic [2:0]   op8;
   logic [7:0]   a8, b8, result8, led_n8;
   logic         carry8, zero8;

   int errs;
   int checks;

   alu_seq #(.WIDTH(W), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry(carry), .zero(zero), .led_n(led_n)
   );

   alu_seq #(.WIDTH(8), .CNT_W(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .op(op8), .a(a8), .b(b8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .result(result8), .carry(carry8), .zero(zero8), .led_n(led_n8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference arithmetic on plain integers, modulo 2^W.
   function automatic void model(input int o, input int av, input int bv, output int r, output int c);
      int m;
      int t;
      m = 1 << W;
      r = 0;
      c = 0;
      case (o)
         0: begin t = av + bv; r = t % m; c = (t >= m) ? 1 : 0; end
         1: begin r = (av - bv + m) % m; c = (av < bv) ? 1 : 0; end
         2: r = av & bv;
         3: r = av | bv;
         4: r = av ^ bv;
         5: r = (bv >= W) ? 0 : (av * (1 << bv)) % m;
         6: r = (bv >= W) ? 0 : av / (1 << bv);
         7: begin t = av * bv; r = t % m; c = (t >= m) ? 1 : 0; end
         default: r = 0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, check latency and outputs, hold for 'hold' cycles
   // of backpressure with junk requests, then consume.
   task automatic run_op(input int o, input int av, input int bv, input int hold);
      int er, ec, lat, wc;
      model(o, av, bv, er, ec);
      wc = 0;
      while (in_ready !== 1'b1 && wc < 20) begin
         tick();
         wc++;
      end
      check_eq("in_ready_wait", in_ready, 1);
      op = o[2:0]; a = av[W-1:0]; b = bv[W-1:0];
      in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      op = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
      check_eq("in_ready_busy", in_ready, 0);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check_eq("latency", lat, (o == 7) ? W + 1 : 1);
      check_eq("result", result, er);
      check_eq("carry", carry, ec);
      check_eq("zero", zero, (er == 0) ? 1 : 0);
      check_eq("led_n", led_n, (~er) & ((1 << W) - 1));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         op = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
         tick();
         check_eq("bp_valid", out_valid, 1);
         check_eq("bp_ready", in_ready, 0);
         check_eq("bp_result", result, er);
         check_eq("bp_led_n", led_n, (~er) & ((1 << W) - 1));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("consumed_valid", out_valid, 0);
      check_eq("consumed_result", result, er);
   endtask

   initial begin
      int lat;
      errs = 0; checks = 0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = '0; b = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; op8 = 3'd0; a8 = 8'd0; b8 = 8'd0;
      repeat (3) tick();
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_result", result, 0);
      check_eq("rst_carry", carry, 0);
      check_eq("rst_zero", zero, 0);
      check_eq("rst_led_n", led_n, 3'b111);
      rst = 1'b0;
      tick();
      check_eq("post_rst_ready", in_ready, 1);

      // WIDTH=8 instance: ADD 7+1 and an overflowing MUL.
      check_eq("w8_ready", in_ready8, 1);
      op8 = 3'd0; a8 = 8'd7; b8 = 8'd1; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      check_eq("w8_add_valid", out_valid8, 1);
      check_eq("w8_add_result", result8, 8);
      check_eq("w8_add_carry", carry8, 0);
      check_eq("w8_add_led_n", led_n8, 8'hF7);
      tick();
      check_eq("w8_ready2", in_ready8, 1);
      op8 = 3'd7; a8 = 8'd200; b8 = 8'd3; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      lat = 1;
      while (out_valid8 !== 1'b1 && lat < 30) begin
         tick();
         lat++;
      end
      check_eq("w8_mul_latency", lat, 9);
      check_eq("w8_mul_result", result8, (200 * 3) % 256);
      check_eq("w8_mul_carry", carry8, 1);
      tick();

      // Directed cases at WIDTH=3.
      run_op(0, 2, 3, 5);
      run_op(1, 2, 3, 0);
      run_op(2, 2, 5, 0);
      run_op(7, 3, 3, 1);
      run_op(7, 2, 3, 0);
      run_op(5, 3, 1, 0);
      run_op(6, 6, 2, 0);
      run_op(5, 3, 3, 0);
      run_op(0, 7, 7, 0);

      // Reset on the second MUL cycle discards the multiply.
      op = 3'd7; a = 3'd3; b = 3'd3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("midrst_valid", out_valid, 0);
      check_eq("midrst_result", result, 0);
      check_eq("midrst_led_n", led_n, 3'b111);
      check_eq("midrst_carry", carry, 0);
      check_eq("midrst_ready", in_ready, 0);
      tick();
      check_eq("midrst_ready_after", in_ready, 1);
      run_op(0, 2, 3, 0);

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
